// File: rtl/mem_sched_pkg.sv
// Shared types and helpers for the memory port scheduler.
// Port index layout: write ports first, read ports from FIRST_READ_PORT upward.
package mem_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        GRANT,
        WAIT_DONE
    } state_t;

    localparam int PORT_IDX_W      = 3;
    localparam int FIRST_READ_PORT = 4;
    localparam int NUM_WRITE_PORTS = 4;

    // Burst length is the pending level capped at the maximum burst size.
    function automatic logic [15:0] burst_clip(input logic [15:0] level, input logic [15:0] max_len);
        return (level > max_len) ? max_len : level;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating first-set finder: returns the first requesting index at or after start, wrapping.
// Purely combinational; found is low when no request bit is set.
module rr_picker
    import mem_sched_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = PORT_IDX_W
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int i = 0; i < N; i++) begin
            pos = (int'(start) + i) % N;
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/mem_port_scheduler.sv
// Issues one bounded burst grant at a time to the memory transfer engine, round-robin over ports.
// MEM_SCHED_PRIORITY_BOOST_EN: urgent read ports with pending data win the scan ahead of others.
module mem_port_scheduler
    import mem_sched_pkg::*;
#(
    parameter int NUM_PORTS   = 8,
    parameter int LEVEL_WIDTH = 11,
    parameter int MAX_BURST   = 256,
    parameter int TIMEOUT     = 4096
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [NUM_PORTS*LEVEL_WIDTH-1:0] port_level,
    input  logic [NUM_PORTS-1:0]             port_urgent,
    output logic                             grant_valid,
    output logic [PORT_IDX_W-1:0]            grant_port,
    output logic [LEVEL_WIDTH-1:0]           grant_len,
    input  logic                             grant_ack,
    input  logic                             xfer_done,
    output logic                             busy,
    output logic                             timeout_err,
    output logic [15:0]                      grant_count
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t                 state, next_state;
    logic [PORT_IDX_W-1:0]  rr_ptr;
    logic [PORT_IDX_W-1:0]  start_idx;
    logic [NUM_PORTS-1:0]   nonzero;
    logic                   rr_found;
    logic [PORT_IDX_W-1:0]  rr_idx;
    logic                   pick_found;
    logic [PORT_IDX_W-1:0]  pick_idx;
    logic [LEVEL_WIDTH-1:0] pick_level;
    logic [LEVEL_WIDTH-1:0] clip_len;
    logic [WD_W-1:0]        watchdog;
    logic                   wd_expired;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_nonzero
        assign nonzero[p] = |port_level[p*LEVEL_WIDTH +: LEVEL_WIDTH];
    end

    assign start_idx = PORT_IDX_W'((int'(rr_ptr) + 1) % NUM_PORTS);

    rr_picker #(.N(NUM_PORTS), .IDX_W(PORT_IDX_W)) u_rr_pick (
        .req   (nonzero),
        .start (start_idx),
        .found (rr_found),
        .idx   (rr_idx)
    );

`ifdef MEM_SCHED_PRIORITY_BOOST_EN
    logic [NUM_PORTS-1:0]  read_mask;
    logic [NUM_PORTS-1:0]  urgent_req;
    logic                  urg_found;
    logic [PORT_IDX_W-1:0] urg_idx;
    logic                  unused_urgent;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_read_mask
        assign read_mask[p] = (p >= FIRST_READ_PORT);
    end

    assign urgent_req    = nonzero & port_urgent & read_mask;
    assign unused_urgent = ^port_urgent[FIRST_READ_PORT-1:0];

    rr_picker #(.N(NUM_PORTS), .IDX_W(PORT_IDX_W)) u_urg_pick (
        .req   (urgent_req),
        .start (start_idx),
        .found (urg_found),
        .idx   (urg_idx)
    );

    assign pick_found = urg_found | rr_found;
    assign pick_idx   = urg_found ? urg_idx : rr_idx;
`else
    logic unused_urgent;

    assign unused_urgent = ^port_urgent;
    assign pick_found    = rr_found;
    assign pick_idx      = rr_idx;
`endif

    assign pick_level = port_level[int'(pick_idx)*LEVEL_WIDTH +: LEVEL_WIDTH];
    assign clip_len   = LEVEL_WIDTH'(burst_clip(16'(pick_level), 16'(MAX_BURST)));
    assign wd_expired = (watchdog == WD_W'(TIMEOUT - 1));

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (enable) next_state = SCAN;
            end
            SCAN: begin
                if (!enable)         next_state = IDLE;
                else if (pick_found) next_state = GRANT;
            end
            GRANT: begin
                if (grant_ack) next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A burst in flight always finishes; enable only gates what follows it.
                if (xfer_done)       next_state = enable ? SCAN : IDLE;
                else if (wd_expired) next_state = SCAN;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_port  <= '0;
            grant_len   <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            grant_count <= '0;
            rr_ptr      <= PORT_IDX_W'(NUM_PORTS - 1);
            watchdog    <= '0;
        end else begin
            state       <= next_state;
            grant_valid <= (next_state == GRANT);
            busy        <= (next_state == GRANT) || (next_state == WAIT_DONE);

            if (state == SCAN && next_state == GRANT) begin
                grant_port <= pick_idx;
                grant_len  <= clip_len;
            end

            if (state == GRANT && grant_ack)
                watchdog <= '0;
            else if (state == WAIT_DONE)
                watchdog <= watchdog + WD_W'(1);

            if (state == WAIT_DONE) begin
                if (xfer_done) begin
                    rr_ptr      <= grant_port;
                    grant_count <= grant_count + 16'd1;
                end else if (wd_expired) begin
                    rr_ptr      <= grant_port;
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule
